// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-requester RAM port arbiter.
package ram_arb_pkg;
    localparam int NUM_REQ    = 2;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/grant/data bundle between the requesters (master) and the arbiter (slave).
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_gnt;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_gnt, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_gnt, rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, 1-bit priority pointer register.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (req == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    // Priority passes to the other requester after every grant; held when idle.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (gnt[0])
            ptr <= 1'b1;
        else if (gnt[1])
            ptr <= 1'b0;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrated 1W/1R RAM shared by two requesters.
// Define RAM_ARB_WR_BYPASS_EN for write-first forwarding on same-address collisions.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input logic                clk,
    input logic                rst,
    ram_port_arbiter_if.slave  bus
);
    logic [NUM_REQ-1:0] wr_gnt;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  wdata;
    logic [ADDR_W-1:0]  raddr;
    logic [DATA_W-1:0]  mem [2**ADDR_W];

    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(bus.wr_req), .gnt(wr_gnt));
    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(bus.rd_req), .gnt(rd_gnt));

    assign bus.wr_gnt = wr_gnt;
    assign bus.rd_gnt = rd_gnt;

    always_comb begin
        waddr = wr_gnt[1] ? bus.wr_addr[ADDR_W +: ADDR_W] : bus.wr_addr[0 +: ADDR_W];
        wdata = wr_gnt[1] ? bus.wr_data[DATA_W +: DATA_W] : bus.wr_data[0 +: DATA_W];
        raddr = rd_gnt[1] ? bus.rd_addr[ADDR_W +: ADDR_W] : bus.rd_addr[0 +: ADDR_W];
    end

    // Memory is intentionally not reset; grants are already zero during rst.
    always_ff @(posedge clk) begin
        if (|wr_gnt)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= rd_gnt;
            if (|rd_gnt) begin
`ifdef RAM_ARB_WR_BYPASS_EN
                if ((|wr_gnt) && (waddr == raddr))
                    bus.rd_data <= wdata;
                else
                    bus.rd_data <= mem[raddr];
`else
                bus.rd_data <= mem[raddr];
`endif
            end
        end
    end
endmodule
